arrow_lane_scheduler: RTL and testbench
=======================================

Name: arrow_lane_scheduler

Overview:
Sequencer that owns the two 26-slot arrow arrays and the two judgement indicators consumed by the pixel index/renderer block. It fetches the song chart from a song ROM over a req/valid handshake, scrolls arrows one slot down every STEP_DIV frame ticks, and judges player presses against the hit zone. It also keeps per-player scores and reports song completion.

Parameters:
SLOTS, 26, arrow slots per player (slot 0 top, slot SLOTS-1 bottom)
STEP_DIV, 4, frame ticks per scroll step (>=1)
HOLD_STEPS, 8, scroll steps an indicator stays visible
EXCELLENT_SLOT, 23, hit-zone centre slot; EXCELLENT_SLOT±1 = good
ADDR_W, 12, song ROM address width
SCORE_W, 16, score counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  pulse: clear state, begin song from address 0
frame_tick  in  1  one-cycle pulse per video frame
p1_press  in  3  arrow code pressed this cycle (000 = none)
p2_press  in  3  as p1
song_req  out  1  ROM read request, held until song_valid
song_addr  out  ADDR_W  ROM address
song_valid  in  1  song_data valid (ROM latency arbitrary, >=1)
song_data  in  6  [5:3] p2 code, [2:0] p1 code; 6'b111111 = end of song
p1_arrow_array  out  3*SLOTS  slot k at bits [3k+2:3k]
p2_arrow_array  out  3*SLOTS  as p1
p1_indicator  out  2  11 excellent, 10 good, 01 bad, 00 none
p2_indicator  out  2  as p1
p1_score  out  SCORE_W  saturating score
p2_score  out  SCORE_W  saturating score
busy  out  1  high in FETCH/WAIT/DRAIN
done  out  1  high in DONE until next start
step_overrun  out  1  sticky: step came due while fetch pending

Behaviour:
- Arrow codes: 000 empty, 001 up, 010 left, 011 down, 100 right, 110 shake; 101/111 from ROM treated as empty.
- Reset: all outputs 0, state IDLE, tick counter 0, song_addr 0.
- States: IDLE, WAIT, FETCH, DRAIN, DONE. start (any state except during reset) -> clear arrays, scores, indicators, hold counters, overrun, song_addr; go WAIT. reset overrides start.
- Tick counter counts frame_tick in WAIT/FETCH/DRAIN; on tick with counter==STEP_DIV-1, wrap to 0 and step is due.
- WAIT: step due -> FETCH, assert song_req next cycle.
- FETCH: song_req=1 until song_valid cycle. On song_valid: if end marker, shift with 000 into slot 0, go DRAIN with drain counter=SLOTS-1; else shift with song codes into slot 0, song_addr+1 (wraps at 2^ADDR_W), go WAIT. Step due while in FETCH: step dropped, step_overrun set.
- DRAIN: each due step shifts 000 in; after SLOTS total end-of-song shifts (array all clear) go DONE. done=1 only in DONE.
- Shift: slot k+1 <= slot k, slot 0 <= new code; slot SLOTS-1 nonempty before shift = miss -> indicator 01.
- Judgement (WAIT/FETCH/DRAIN, per player independently, same cycle as press): search EXCELLENT_SLOT, then -1, then +1 for matching code; first match: clear slot, indicator 11 (+2 score) or 10 (+1 score). No match: indicator 01, score unchanged. Press in IDLE/DONE ignored.
- Press and shift same cycle: judge pre-shift array; cleared slot then shifts as empty. Press result overrides miss in the same cycle.
- Any new judgement reloads hold counter to HOLD_STEPS; each shift decrements; at 0 indicator -> 00.
- Scores saturate at all-ones.
- Outputs registered; arrays/indicators visible one cycle after causing event.

Decomposition:
- Shared package: arrow code constants, indicator codes, END_MARKER, SLOTS default.
- Sub-module lane_judge (one per player): arrow array register, shift, hit search, indicator/hold, score; top holds FSM, tick counter, ROM handshake.

Test Plan:
- Reset mid-FETCH with song_req=1 -> next cycle song_req=0, arrays 0, state IDLE, done=0.
- start, STEP_DIV=4, ROM latency 3, data 6'b010_001 -> song_req after 4th tick, slot 0 = p1 001 / p2 010 one cycle after song_valid, song_addr=1.
- Up arrow scrolled to slot 23, p1_press=001 -> slot 23 cleared, p1_indicator=11, p1_score=2; after 8 steps indicator=00.
- Arrow at slot 22 pressed -> 10, score +1; press with hit zone empty -> 01, score unchanged; arrow leaving slot 25 unpressed -> 01.
- Press and shift same cycle, arrow at 24 -> judged good, no miss from it.
- ROM returns 111111 at address 5 -> DRAIN, 26 steps later arrays 0 and done=1; ROM latency > 4 ticks -> step_overrun=1.

Source files
------------

// File: rtl/arrow_lane_scheduler_pkg.sv
// Shared definitions for the arrow lane scheduler: arrow/indicator codes,
// the song end marker, FSM state type and the ROM arrow decode helper.
package arrow_lane_scheduler_pkg;

    localparam int SLOTS_DEFAULT = 26;

    localparam logic [2:0] ARROW_NONE  = 3'b000;
    localparam logic [2:0] ARROW_UP    = 3'b001;
    localparam logic [2:0] ARROW_LEFT  = 3'b010;
    localparam logic [2:0] ARROW_DOWN  = 3'b011;
    localparam logic [2:0] ARROW_RIGHT = 3'b100;
    localparam logic [2:0] ARROW_SHAKE = 3'b110;

    localparam logic [1:0] IND_NONE      = 2'b00;
    localparam logic [1:0] IND_BAD       = 2'b01;
    localparam logic [1:0] IND_GOOD      = 2'b10;
    localparam logic [1:0] IND_EXCELLENT = 2'b11;

    localparam logic [5:0] END_MARKER = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    // Unassigned codes coming from the ROM are shown as empty slots.
    function automatic logic [2:0] decode_arrow(input logic [2:0] raw);
        case (raw)
            ARROW_UP, ARROW_LEFT, ARROW_DOWN, ARROW_RIGHT, ARROW_SHAKE: return raw;
            default: return ARROW_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arrow_lane_scheduler_if.sv
// Song ROM read handshake: request/address out, valid/data back.
interface arrow_lane_scheduler_if #(
    parameter int ADDR_W = 12
);
    logic              song_req;
    logic [ADDR_W-1:0] song_addr;
    logic              song_valid;
    logic [5:0]        song_data;

    modport master (output song_req, song_addr, input song_valid, song_data);
    modport slave  (input song_req, song_addr, output song_valid, song_data);
endinterface

// File: rtl/arrow_lane_scheduler_lane_judge.sv
// One player's lane: arrow shift register, hit-zone judgement,
// indicator with hold timer and saturating score.
module arrow_lane_scheduler_lane_judge
    import arrow_lane_scheduler_pkg::*;
#(
    parameter int SLOTS          = SLOTS_DEFAULT,
    parameter int HOLD_STEPS     = 8,
    parameter int EXCELLENT_SLOT = 23,
    parameter int SCORE_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 active,
    input  logic                 shift,
    input  logic [2:0]           shift_code,
    input  logic [2:0]           press,
    output logic [3*SLOTS-1:0]   arrow_array,
    output logic [1:0]           indicator,
    output logic [SCORE_W-1:0]   score
);

    localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
    localparam int EXC_LO = 3 * EXCELLENT_SLOT;
    localparam int GD1_LO = 3 * (EXCELLENT_SLOT - 1);
    localparam int GD2_LO = 3 * (EXCELLENT_SLOT + 1);
    localparam int BOT_LO = 3 * (SLOTS - 1);

    logic [3*SLOTS-1:0] arrow_reg, arrow_next, work;
    logic [1:0]         indicator_reg, indicator_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [SCORE_W:0]   sum;
    logic [1:0]         pts;
    logic               judged;

    always_comb begin
        work           = arrow_reg;
        arrow_next     = arrow_reg;
        indicator_next = indicator_reg;
        hold_next      = hold_reg;
        pts            = 2'd0;
        judged         = 1'b0;

        // The press sees the pre-shift array; a hit slot then shifts as empty.
        if (active && press != ARROW_NONE) begin
            judged    = 1'b1;
            hold_next = HOLD_W'(HOLD_STEPS);
            if (work[EXC_LO +: 3] == press) begin
                work[EXC_LO +: 3] = ARROW_NONE;
                indicator_next    = IND_EXCELLENT;
                pts               = 2'd2;
            end else if (work[GD1_LO +: 3] == press) begin
                work[GD1_LO +: 3] = ARROW_NONE;
                indicator_next    = IND_GOOD;
                pts               = 2'd1;
            end else if (work[GD2_LO +: 3] == press) begin
                work[GD2_LO +: 3] = ARROW_NONE;
                indicator_next    = IND_GOOD;
                pts               = 2'd1;
            end else begin
                indicator_next = IND_BAD;
            end
        end

        if (shift) begin
            arrow_next = {work[3*SLOTS-4:0], shift_code};
            if (!judged) begin
                if (work[BOT_LO +: 3] != ARROW_NONE) begin
                    indicator_next = IND_BAD;
                    hold_next      = HOLD_W'(HOLD_STEPS);
                end else if (hold_reg != '0) begin
                    hold_next = hold_reg - HOLD_W'(1);
                    if (hold_reg == HOLD_W'(1)) indicator_next = IND_NONE;
                end
            end
        end else begin
            arrow_next = work;
        end

        sum        = {1'b0, score_reg} + (SCORE_W+1)'(pts);
        score_next = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            arrow_reg     <= '0;
            indicator_reg <= IND_NONE;
            hold_reg      <= '0;
            score_reg     <= '0;
        end else begin
            arrow_reg     <= arrow_next;
            indicator_reg <= indicator_next;
            hold_reg      <= hold_next;
            score_reg     <= score_next;
        end
    end

    assign arrow_array = arrow_reg;
    assign indicator   = indicator_reg;
    assign score       = score_reg;

endmodule

// File: rtl/arrow_lane_scheduler.sv
// Song sequencer: frame-tick step timer, song ROM fetch FSM and end-of-song
// drain, driving one lane_judge per player.
module arrow_lane_scheduler
    import arrow_lane_scheduler_pkg::*;
#(
    parameter int SLOTS          = SLOTS_DEFAULT,
    parameter int STEP_DIV       = 4,
    parameter int HOLD_STEPS     = 8,
    parameter int EXCELLENT_SLOT = 23,
    parameter int ADDR_W         = 12,
    parameter int SCORE_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 frame_tick,
    input  logic [2:0]           p1_press,
    input  logic [2:0]           p2_press,
    arrow_lane_scheduler_if.master song,
    output logic [3*SLOTS-1:0]   p1_arrow_array,
    output logic [3*SLOTS-1:0]   p2_arrow_array,
    output logic [1:0]           p1_indicator,
    output logic [1:0]           p2_indicator,
    output logic [SCORE_W-1:0]   p1_score,
    output logic [SCORE_W-1:0]   p2_score,
    output logic                 busy,
    output logic                 done,
    output logic                 step_overrun
);

    localparam int TICK_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DRAIN_W = $clog2(SLOTS);

    sched_state_t       state_reg, state_next;
    logic [TICK_W-1:0]  tick_reg, tick_next;
    logic [DRAIN_W-1:0] drain_reg, drain_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic               overrun_reg, overrun_next;
    logic               req_reg, busy_reg, done_reg;
    logic               active, step_due, shift;
    logic [2:0]         new_code [2];
    logic [2:0]         press_w [2];
    logic [3*SLOTS-1:0] arr_w [2];
    logic [1:0]         ind_w [2];
    logic [SCORE_W-1:0] score_w [2];

    assign active   = (state_reg == ST_WAIT) || (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign step_due = active && frame_tick && (tick_reg == TICK_W'(STEP_DIV - 1));

    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        drain_next   = drain_reg;
        addr_next    = addr_reg;
        overrun_next = overrun_reg;
        shift        = 1'b0;
        new_code[0]  = ARROW_NONE;
        new_code[1]  = ARROW_NONE;

        if (active && frame_tick) tick_next = step_due ? '0 : tick_reg + TICK_W'(1);

        case (state_reg)
            ST_WAIT: if (step_due) state_next = ST_FETCH;
            ST_FETCH: begin
                // A step falling due while the ROM is still busy is lost.
                if (step_due) overrun_next = 1'b1;
                if (song.song_valid) begin
                    shift = 1'b1;
                    if (song.song_data == END_MARKER) begin
                        state_next = ST_DRAIN;
                        drain_next = DRAIN_W'(SLOTS - 1);
                    end else begin
                        new_code[0] = decode_arrow(song.song_data[2:0]);
                        new_code[1] = decode_arrow(song.song_data[5:3]);
                        addr_next   = addr_reg + ADDR_W'(1);
                        state_next  = ST_WAIT;
                    end
                end
            end
            ST_DRAIN: if (step_due) begin
                shift = 1'b1;
                if (drain_reg == DRAIN_W'(1)) state_next = ST_DONE;
                else drain_next = drain_reg - DRAIN_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || start) begin
            state_reg   <= reset ? ST_IDLE : ST_WAIT;
            tick_reg    <= '0;
            drain_reg   <= '0;
            addr_reg    <= '0;
            overrun_reg <= 1'b0;
            req_reg     <= 1'b0;
            busy_reg    <= !reset;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            drain_reg   <= drain_next;
            addr_reg    <= addr_next;
            overrun_reg <= overrun_next;
            req_reg     <= (state_next == ST_FETCH);
            busy_reg    <= (state_next == ST_WAIT) || (state_next == ST_FETCH) || (state_next == ST_DRAIN);
            done_reg    <= (state_next == ST_DONE);
        end
    end

    assign press_w[0] = p1_press;
    assign press_w[1] = p2_press;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            arrow_lane_scheduler_lane_judge #(
                .SLOTS          (SLOTS),
                .HOLD_STEPS     (HOLD_STEPS),
                .EXCELLENT_SLOT (EXCELLENT_SLOT),
                .SCORE_W        (SCORE_W)
            ) u_lane (
                .clock       (clock),
                .reset       (reset),
                .clear       (start),
                .active      (active),
                .shift       (shift),
                .shift_code  (new_code[gi]),
                .press       (press_w[gi]),
                .arrow_array (arr_w[gi]),
                .indicator   (ind_w[gi]),
                .score       (score_w[gi])
            );
        end
    endgenerate

    assign song.song_req  = req_reg;
    assign song.song_addr = addr_reg;
    assign p1_arrow_array = arr_w[0];
    assign p2_arrow_array = arr_w[1];
    assign p1_indicator   = ind_w[0];
    assign p2_indicator   = ind_w[1];
    assign p1_score       = score_w[0];
    assign p2_score       = score_w[1];
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign step_overrun   = overrun_reg;

endmodule

// File: tb/tb_arrow_lane_scheduler.sv
// Randomized bench for arrow_lane_scheduler: a ROM responder plus a
// behavioural game model checked against every output each cycle.
module tb_arrow_lane_scheduler;
    import arrow_lane_scheduler_pkg::*;

    localparam int SLOTS = 26, STEP_DIV = 4, HOLD_STEPS = 8, EXC = 23;
    localparam int ADDR_W = 12, SCORE_W = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset, start, frame_tick;
    logic [2:0]           p1_press, p2_press;
    logic [3*SLOTS-1:0]   p1_arrow_array, p2_arrow_array;
    logic [1:0]           p1_indicator, p2_indicator;
    logic [SCORE_W-1:0]   p1_score, p2_score;
    logic                 busy, done, step_overrun;

    arrow_lane_scheduler_if #(.ADDR_W(ADDR_W)) song_bus ();

    arrow_lane_scheduler #(
        .SLOTS(SLOTS), .STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD_STEPS),
        .EXCELLENT_SLOT(EXC), .ADDR_W(ADDR_W), .SCORE_W(SCORE_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
        .p1_press(p1_press), .p2_press(p2_press), .song(song_bus),
        .p1_arrow_array(p1_arrow_array), .p2_arrow_array(p2_arrow_array),
        .p1_indicator(p1_indicator), .p2_indicator(p2_indicator),
        .p1_score(p1_score), .p2_score(p2_score),
        .busy(busy), .done(done), .step_overrun(step_overrun)
    );

    int tests_run, tests_failed;
    logic [5:0] rom [64];
    int rom_wait, rom_lat;
    bit long_lat;

    // Game model: 0 idle, 1 waiting for step, 2 fetching, 3 draining, 4 done
    int m_state, m_tick, m_addr, m_drain, m_over, m_req;
    int m_arr [2][SLOTS];
    int m_ind [2], m_hold [2], m_score [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_state = 0; m_tick = 0; m_addr = 0; m_drain = 0; m_over = 0; m_req = 0;
        for (int p = 0; p < 2; p++) begin
            m_ind[p] = 0; m_hold[p] = 0; m_score[p] = 0;
            for (int k = 0; k < SLOTS; k++) m_arr[p][k] = 0;
        end
    endtask

    task automatic model_update(input bit rs, input bit st, input bit tk,
                                input int pa, input int pb, input bit vld, input int dat);
        int pr [2];
        int code [2];
        int idx;
        bit act, step, shift, judged;
        pr[0] = pa; pr[1] = pb;
        code[0] = 0; code[1] = 0;
        if (rs) begin model_clear(); return; end
        if (st) begin model_clear(); m_state = 1; return; end
        act = (m_state >= 1 && m_state <= 3);
        step = 0; shift = 0;
        if (act && tk) begin
            m_tick++;
            if (m_tick == STEP_DIV) begin m_tick = 0; step = 1; end
        end
        if (m_state == 1 && step) begin
            m_state = 2; m_req = 1;
        end else if (m_state == 2) begin
            if (step) m_over = 1;
            if (vld) begin
                m_req = 0; shift = 1;
                if (dat == 63) begin
                    m_state = 3; m_drain = SLOTS - 1;
                end else begin
                    code[0] = dat % 8; code[1] = dat / 8;
                    for (int p = 0; p < 2; p++) if (code[p] == 5 || code[p] == 7) code[p] = 0;
                    m_addr = (m_addr + 1) % (1 << ADDR_W);
                    m_state = 1;
                end
            end
        end else if (m_state == 3 && step) begin
            shift = 1; m_drain--;
            if (m_drain == 0) m_state = 4;
        end
        for (int p = 0; p < 2; p++) begin
            judged = 0;
            if (act && pr[p] != 0) begin
                judged = 1; idx = -1;
                if (m_arr[p][EXC] == pr[p]) idx = EXC;
                else if (m_arr[p][EXC-1] == pr[p]) idx = EXC - 1;
                else if (m_arr[p][EXC+1] == pr[p]) idx = EXC + 1;
                if (idx < 0) m_ind[p] = 1;
                else begin
                    m_arr[p][idx] = 0;
                    m_ind[p] = (idx == EXC) ? 3 : 2;
                    m_score[p] += (idx == EXC) ? 2 : 1;
                    if (m_score[p] > 65535) m_score[p] = 65535;
                end
                m_hold[p] = HOLD_STEPS;
            end
            if (shift) begin
                if (!judged && m_arr[p][SLOTS-1] != 0) begin
                    m_ind[p] = 1; m_hold[p] = HOLD_STEPS;
                end else if (!judged && m_hold[p] > 0) begin
                    m_hold[p]--;
                    if (m_hold[p] == 0) m_ind[p] = 0;
                end
                for (int k = SLOTS - 1; k > 0; k--) m_arr[p][k] = m_arr[p][k-1];
                m_arr[p][0] = code[p];
            end
        end
    endtask

    task automatic check_all();
        logic [127:0] e0, e1;
        e0 = '0; e1 = '0;
        for (int k = 0; k < SLOTS; k++) begin
            e0[3*k +: 3] = 3'(m_arr[0][k]);
            e1[3*k +: 3] = 3'(m_arr[1][k]);
        end
        chk("p1_arrow_array", p1_arrow_array, e0);
        chk("p2_arrow_array", p2_arrow_array, e1);
        chk("p1_indicator", p1_indicator, m_ind[0]);
        chk("p2_indicator", p2_indicator, m_ind[1]);
        chk("p1_score", p1_score, m_score[0]);
        chk("p2_score", p2_score, m_score[1]);
        chk("song_req", song_bus.song_req, m_req);
        chk("song_addr", song_bus.song_addr, m_addr);
        chk("busy", busy, (m_state >= 1 && m_state <= 3));
        chk("done", done, (m_state == 4));
        chk("step_overrun", step_overrun, m_over);
    endtask

    function automatic int next_lat();
        return long_lat ? $urandom_range(12, 20) : $urandom_range(1, 3);
    endfunction

    // Bias presses toward whatever sits in the hit zone so hits actually occur.
    function automatic logic [2:0] pick_press(input int p);
        int r = $urandom_range(0, 9);
        if (r < 3) return 3'(m_arr[p][$urandom_range(EXC - 1, EXC + 1)]);
        if (r == 3) return 3'($urandom_range(1, 7));
        return 3'd0;
    endfunction

    task automatic cycle(input bit rs, input bit st, input bit tk,
                         input logic [2:0] a, input logic [2:0] b);
        bit vld;
        int dat;
        reset = rs; start = st; frame_tick = tk; p1_press = a; p2_press = b;
        vld = 0; dat = 0;
        if (song_bus.song_req === 1'b1) begin
            if (rom_wait >= rom_lat - 1) begin
                vld = 1; dat = int'(rom[song_bus.song_addr[5:0]]);
                rom_wait = 0; rom_lat = next_lat();
            end else rom_wait++;
        end
        if (rs || st) rom_wait = 0;
        song_bus.song_valid = vld;
        song_bus.song_data  = 6'(dat);
        @(posedge clock);
        model_update(rs, st, tk, int'(a), int'(b), vld, dat);
        #1 check_all();
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rom_wait = 0; long_lat = 0; rom_lat = 3;
        for (int i = 0; i < 64; i++) rom[i] = 6'($urandom_range(0, 62));
        rom[0] = 6'b010_001;
        model_clear();

        repeat (3) cycle(1, 0, 0, 3'd0, 3'd0);

        // Begin a song, wait for the ROM request, then reset mid-fetch.
        cycle(0, 1, 0, 3'd0, 3'd0);
        for (int i = 0; i < 40 && m_req == 0; i++) cycle(0, 0, 1, 3'd0, 3'd0);
        chk("fetch_req_reached", song_bus.song_req, 1);
        cycle(1, 0, 0, 3'd0, 3'd0);
        cycle(0, 0, 1, 3'd1, 3'd2);

        // Song A: 40 entries then end marker, short ROM latency, random play.
        rom[40] = END_MARKER;
        rom_lat = 3;
        cycle(0, 1, 0, 3'd0, 3'd0);
        for (int i = 0; i < 4000 && m_state != 4; i++)
            cycle(0, 0, ($urandom_range(0, 2) == 0), pick_press(0), pick_press(1));
        chk("song_a_done", done, 1);
        chk("song_a_arrays_clear", p1_arrow_array | p2_arrow_array, 0);

        // Presses after the song has finished must be ignored.
        repeat (5) cycle(0, 0, 1, 3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)));

        // Song B: end marker at address 5, ROM slower than one step.
        for (int i = 0; i < 5; i++) rom[i] = 6'($urandom_range(0, 62));
        rom[5] = END_MARKER;
        long_lat = 1; rom_lat = 15;
        cycle(0, 1, 0, 3'd0, 3'd0);
        for (int i = 0; i < 2000 && m_state != 4; i++)
            cycle(0, 0, 1, pick_press(0), pick_press(1));
        chk("song_b_done", done, 1);
        chk("song_b_overrun", step_overrun, 1);
        chk("song_b_addr", song_bus.song_addr, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
